// File: rtl/coconut_pkg.sv
// Shared types and constants for the coconut search controller.
// Imported by the controller RTL and by the benches.
package coconut_pkg;
  localparam int CW_DEF    = 32;
  localparam int FIRST_SOL = 15621;

  typedef enum logic [1:0] {
    IDLE,
    PROBE,
    EMIT,
    FIN
  } state_t;
endpackage

// File: rtl/coconut_search_ctrl.sv
// Sweeps candidate counts into the allocator one per cycle and streams
// each valid count out over a ready/valid handshake.
module coconut_search_ctrl
  import coconut_pkg::*;
#(
  parameter  int CW       = CW_DEF,
  parameter  int START    = 1,
  parameter  int STEP     = 5,
  parameter  int NUM_SOL  = 4,
  parameter  int MAX_CAND = 1000000,
  localparam int IW = (NUM_SOL > 1) ? $clog2(NUM_SOL) : 1,
  localparam int FW = $clog2(NUM_SOL + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] coconuts,
  input  logic          alloc_valid,
  output logic          sol_valid,
  input  logic          sol_ready,
  output logic [CW-1:0] sol_count,
  output logic [IW-1:0] sol_index,
  output logic          busy,
  output logic          done,
  output logic          exhausted
);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_coconuts;
  logic [CW-1:0] r_lim;
  logic [FW-1:0] r_found;
  logic [CW-1:0] r_sol_count;
  logic [IW-1:0] r_sol_index;
  logic          r_exhausted;

  logic [CW:0]   w_sum;
  logic          w_over;
  logic          w_hs;
  logic [FW-1:0] w_found_nx;
  logic          w_last;

  // Sum kept one bit wider so a sweep near the top of the range never wraps.
  assign w_sum      = {1'b0, r_coconuts} + (CW+1)'(STEP);
  assign w_over     = w_sum > {1'b0, r_lim};
  assign w_hs       = sol_valid && sol_ready;
  assign w_found_nx = r_found + 1'b1;
  assign w_last     = w_found_nx == FW'(NUM_SOL);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:  if (start) w_next = PROBE;
      PROBE: begin
        if (alloc_valid) w_next = EMIT;
        else if (w_over) w_next = FIN;
      end
      EMIT: begin
        if (w_hs) begin
          if (w_last || w_over) w_next = FIN;
          else                  w_next = PROBE;
        end
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_coconuts  <= '0;
      r_lim       <= '0;
      r_found     <= '0;
      r_sol_count <= '0;
      r_sol_index <= '0;
      r_exhausted <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_coconuts  <= CW'(START);
            r_lim       <= (limit == '0) ? CW'(MAX_CAND) : limit;
            r_found     <= '0;
            r_exhausted <= 1'b0;
          end
        end
        PROBE: begin
          if (alloc_valid) begin
            r_sol_count <= r_coconuts;
            r_sol_index <= IW'(r_found);
          end else if (w_over) begin
            r_exhausted <= 1'b1;
          end else begin
            r_coconuts <= w_sum[CW-1:0];
          end
        end
        EMIT: begin
          if (w_hs) begin
            r_found <= w_found_nx;
            if (!w_last) begin
              if (w_over) r_exhausted <= 1'b1;
              else        r_coconuts  <= w_sum[CW-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign coconuts  = r_coconuts;
  assign sol_valid = r_state == EMIT;
  assign sol_count = r_sol_count;
  assign sol_index = r_sol_index;
  assign busy      = r_state != IDLE;
  assign done      = r_state == FIN;
  assign exhausted = r_exhausted;

endmodule
